// File: rtl/pwm_generator_3phase.sv
// Three-phase edge-aligned PWM generator with one shared period counter and
// double-buffered period/duty values that reload only at a period boundary.
module pwm_generator_3phase #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] pwm_period,
  input  logic [CNT_WIDTH-1:0] duty_a,
  input  logic [CNT_WIDTH-1:0] duty_b,
  input  logic [CNT_WIDTH-1:0] duty_c,
  output logic                 pwm_a,
  output logic                 pwm_b,
  output logic                 pwm_c,
  output logic                 period_tick
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] per_sh;
  logic [CNT_WIDTH-1:0] duty_sh_a;
  logic [CNT_WIDTH-1:0] duty_sh_b;
  logic [CNT_WIDTH-1:0] duty_sh_c;
  logic                 active;
  logic                 reload;

  // A zero period short-circuits the terminal-count term, so the underflow of
  // per_sh - 1 is never used.
  assign active = enable & ~reset & (per_sh != '0);
  assign reload = reset | ~enable | (per_sh == '0) | (cnt == per_sh - CNT_ONE);

  // NOTE: all state is updated with non-blocking assignments so every compare
  // below sees the pre-edge cnt and shadows, giving the one-cycle output lag.
  always_ff @(posedge clk) begin
    if (reload) begin
      cnt       <= '0;
      per_sh    <= pwm_period;
      duty_sh_a <= duty_a;
      duty_sh_b <= duty_b;
      duty_sh_c <= duty_c;
    end else begin
      cnt       <= cnt + CNT_ONE;
    end

    // reset is folded into active, so outputs clear on the reset edge itself.
    pwm_a       <= active & (cnt < duty_sh_a);
    pwm_b       <= active & (cnt < duty_sh_b);
    pwm_c       <= active & (cnt < duty_sh_c);
    period_tick <= active & (cnt == '0);
  end

endmodule

// File: tb/tb_pwm_generator_3phase.sv
// Self-checking bench for pwm_generator_3phase: a per-clock reference model
// feeds a scoreboard queue, and each scenario task adds waveform-level checks.
module tb_pwm_generator_3phase;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] pwm_period;
  logic [15:0] duty_a;
  logic [15:0] duty_b;
  logic [15:0] duty_c;
  logic        pwm_a;
  logic        pwm_b;
  logic        pwm_c;
  logic        period_tick;

  logic [3:0]  obs;
  logic [3:0]  exp_out;
  logic [3:0]  model_exp;
  logic [3:0]  sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  int m_cnt = 0, m_per = 0, m_da = 0, m_db = 0, m_dc = 0;
  bit m_act;

  pwm_generator_3phase #(.CNT_WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pwm_period  (pwm_period),
    .duty_a      (duty_a),
    .duty_b      (duty_b),
    .duty_c      (duty_c),
    .pwm_a       (pwm_a),
    .pwm_b       (pwm_b),
    .pwm_c       (pwm_c),
    .period_tick (period_tick)
  );

  assign obs = {pwm_a, pwm_b, pwm_c, period_tick};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: predicts what each edge registers, then advances its state.
  always @(posedge clk) begin
    m_act     = enable && !reset && (m_per != 0);
    model_exp = {m_act && (m_cnt < m_da), m_act && (m_cnt < m_db),
                 m_act && (m_cnt < m_dc), m_act && (m_cnt == 0)};
    sb.push_back(model_exp);
    if (reset || !enable || m_per == 0 || m_cnt == m_per - 1) begin
      m_cnt = 0;
      m_per = int'(pwm_period);
      m_da  = int'(duty_a);
      m_db  = int'(duty_b);
      m_dc  = int'(duty_c);
    end else begin
      m_cnt = m_cnt + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // Advances one clock and pops the expectation for the edge just taken.
  task automatic cycle();
    @(negedge clk);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty: got empty queue, required one entry per clock");
      exp_out = 'x;
    end else begin
      exp_out = sb.pop_front();
    end
  endtask

  task automatic set_inputs(input int per, input int da, input int db, input int dc);
    pwm_period = 16'(per);
    duty_a     = 16'(da);
    duty_b     = 16'(db);
    duty_c     = 16'(dc);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b0;
    set_inputs(1000, 500, 300, 200);
    cycle();
    n_checks++;
    if (obs !== 4'b0000) begin
      n_fail++; $display("FAIL reset_outputs: got %b required 0000", obs);
    end
    n_checks++;
    if (obs !== exp_out) begin
      n_fail++; $display("FAIL reset_sb: got %b required %b", obs, exp_out);
    end
    reset = 1'b0;
    cycle();
    n_checks++;
    if (obs !== 4'b0000) begin
      n_fail++; $display("FAIL disabled_idle: got %b required 0000", obs);
    end
  endtask

  // Ten 1000-cycle periods with 500/300/200 duties from start-up.
  task automatic test_steady();
    int hi_a, hi_b, hi_c, ticks, stray, pos;
    logic [3:0] prev;
    enable = 1'b1;
    hi_a = 0; hi_b = 0; hi_c = 0; ticks = 0; stray = 0; prev = 4'b0000;
    for (int i = 0; i < 10000; i++) begin
      cycle();
      pos = i % 1000;
      n_checks++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL steady_sb cyc %0d: got %b required %b", i, obs, exp_out);
      end
      hi_a += int'(pwm_a); hi_b += int'(pwm_b); hi_c += int'(pwm_c);
      if (pos == 0) ticks += int'(period_tick);
      else if (period_tick || ((obs[3:1] & ~prev[3:1]) != 3'b000)) stray++;
      prev = obs;
      if (pos == 999) begin
        n_checks++;
        if (hi_a != 500 || hi_b != 300 || hi_c != 200) begin
          n_fail++;
          $display("FAIL steady_duty period %0d: got a/b/c high %0d/%0d/%0d required 500/300/200",
                   i / 1000, hi_a, hi_b, hi_c);
        end
        n_checks++;
        if (ticks != 1 || stray != 0) begin
          n_fail++;
          $display("FAIL steady_align period %0d: got ticks %0d stray %0d required 1 and 0",
                   i / 1000, ticks, stray);
        end
        hi_a = 0; hi_b = 0; hi_c = 0; ticks = 0; stray = 0;
      end
    end
  endtask

  // Duty 0 / duty==period / duty at full scale, loaded at the next reload.
  task automatic test_boundary();
    int bad_a, bad_b, bad_c;
    set_inputs(1000, 0, 1000, 65535);
    bad_a = 0; bad_b = 0; bad_c = 0;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      n_checks++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL boundary_sb cyc %0d: got %b required %b", i, obs, exp_out);
      end
      if (i >= 1000) begin
        if (pwm_a !== 1'b0) bad_a++;
        if (pwm_b !== 1'b1) bad_b++;
        if (pwm_c !== 1'b1) bad_c++;
      end
    end
    n_checks++;
    if (bad_a != 0) begin n_fail++; $display("FAIL duty_zero: got %0d high cycles required 0", bad_a); end
    n_checks++;
    if (bad_b != 0) begin n_fail++; $display("FAIL duty_eq_period: got %0d low cycles required 0", bad_b); end
    n_checks++;
    if (bad_c != 0) begin n_fail++; $display("FAIL duty_full_scale: got %0d low cycles required 0", bad_c); end
  endtask

  // Duty and period changed at cycle 250: the running period completes unchanged.
  task automatic test_mid_update();
    int hi_a, ticks, stray;
    set_inputs(1000, 500, 300, 200);
    for (int i = 0; i < 1000; i++) begin
      cycle();
      n_checks++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL mid_pre_sb cyc %0d: got %b required %b", i, obs, exp_out);
      end
    end
    hi_a = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 250) begin
        pwm_period = 16'd400;
        duty_a     = 16'd100;
      end
      cycle();
      n_checks++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL mid_old_sb cyc %0d: got %b required %b", i, obs, exp_out);
      end
      hi_a += int'(pwm_a);
    end
    n_checks++;
    if (hi_a != 500) begin n_fail++; $display("FAIL mid_old_duty: got %0d high required 500", hi_a); end
    hi_a = 0; ticks = 0; stray = 0;
    for (int i = 0; i < 400; i++) begin
      cycle();
      n_checks++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL mid_new_sb cyc %0d: got %b required %b", i, obs, exp_out);
      end
      hi_a += int'(pwm_a);
      if (i == 0) ticks += int'(period_tick);
      else if (period_tick) stray++;
    end
    n_checks++;
    if (hi_a != 100 || ticks != 1 || stray != 0) begin
      n_fail++;
      $display("FAIL mid_new_period: got high %0d ticks %0d stray %0d required 100, 1, 0",
               hi_a, ticks, stray);
    end
    cycle();
    n_checks++;
    if (period_tick !== 1'b1) begin
      n_fail++; $display("FAIL mid_new_length: got tick %b after 400 cycles required 1", period_tick);
    end
  endtask

  // Period 0 parks everything low; period 10 then restarts on the next edge.
  task automatic test_zero_period();
    int nz, bad;
    logic [3:0] want;
    pwm_period = 16'd0;
    for (int i = 0; i < 400; i++) begin
      cycle();
      n_checks++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL zero_drain_sb cyc %0d: got %b required %b", i, obs, exp_out);
      end
    end
    nz = 0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (obs !== 4'b0000) nz++;
    end
    n_checks++;
    if (nz != 0) begin n_fail++; $display("FAIL zero_period: got %0d active cycles required 0", nz); end
    set_inputs(10, 3, 300, 200);
    cycle();
    n_checks++;
    if (obs !== 4'b0000) begin
      n_fail++; $display("FAIL zero_reload_edge: got %b required 0000", obs);
    end
    bad = 0;
    for (int j = 0; j < 30; j++) begin
      cycle();
      n_checks++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL per10_sb cyc %0d: got %b required %b", j, obs, exp_out);
      end
      want = {(j % 10) < 3, 1'b1, 1'b1, (j % 10) == 0};
      if (obs !== want) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL period10_wave: got %0d bad cycles required 0", bad); end
  endtask

  // Shared by disable and reset recovery: a fresh, complete 1000-cycle period.
  task automatic check_restart(input string tag);
    int hi_a, hi_b, hi_c, stray;
    hi_a = 0; hi_b = 0; hi_c = 0; stray = 0;
    for (int k = 0; k <= 1000; k++) begin
      cycle();
      n_checks++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL %s_sb cyc %0d: got %b required %b", tag, k, obs, exp_out);
      end
      if (k == 0) begin
        n_checks++;
        if (obs !== 4'b1111) begin
          n_fail++; $display("FAIL %s_first: got %b required 1111", tag, obs);
        end
      end
      if (k < 1000) begin
        hi_a += int'(pwm_a); hi_b += int'(pwm_b); hi_c += int'(pwm_c);
        if (k != 0 && period_tick) stray++;
      end else begin
        n_checks++;
        if (period_tick !== 1'b1) begin
          n_fail++; $display("FAIL %s_length: got tick %b at cycle 1000 required 1", tag, period_tick);
        end
      end
    end
    n_checks++;
    if (hi_a != 500 || hi_b != 300 || hi_c != 200 || stray != 0) begin
      n_fail++;
      $display("FAIL %s_period: got high %0d/%0d/%0d stray %0d required 500/300/200 and 0",
               tag, hi_a, hi_b, hi_c, stray);
    end
  endtask

  task automatic test_disable();
    int nz;
    set_inputs(1000, 500, 300, 200);
    for (int i = 0; i < 610; i++) begin
      cycle();
      n_checks++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL dis_pre_sb cyc %0d: got %b required %b", i, obs, exp_out);
      end
    end
    enable = 1'b0;
    cycle();
    n_checks++;
    if (obs !== 4'b0000) begin
      n_fail++; $display("FAIL disable_edge: got %b required 0000", obs);
    end
    nz = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (obs !== 4'b0000) nz++;
    end
    n_checks++;
    if (nz != 0) begin n_fail++; $display("FAIL disable_hold: got %0d active cycles required 0", nz); end
    enable = 1'b1;
    check_restart("reenable");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 300; i++) begin
      cycle();
      n_checks++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL rst_pre_sb cyc %0d: got %b required %b", i, obs, exp_out);
      end
    end
    reset = 1'b1;
    cycle();
    n_checks++;
    if (obs !== 4'b0000) begin
      n_fail++; $display("FAIL reset_mid_edge: got %b required 0000", obs);
    end
    reset = 1'b0;
    check_restart("post_reset");
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    set_inputs(1000, 500, 300, 200);
    test_reset();
    test_steady();
    test_boundary();
    test_mid_update();
    test_zero_period();
    test_disable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
